axis_argmax_10: RTL and testbench



---
 rtl/axis_argmax_10.sv | 151 +++++++++++++++
 tb/tb_axis_argmax_10.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_argmax_10.sv
// Streaming argmax over one fp32 vector per frame, emitting the winning index (bit 31 flags a length error).
// Build option ARGMAX_EMIT_VALUE_EN appends a second beat carrying the winning input word.
module axis_argmax_10 #(
  parameter int unsigned N_ELEMS = 10,
  parameter int unsigned IDX_W   = 4
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic [31:0] INPUT_AXIS_TDATA,
  input  logic        INPUT_AXIS_TLAST,
  input  logic        INPUT_AXIS_TVALID,
  output logic        INPUT_AXIS_TREADY,
  output logic [31:0] OUTPUT_AXIS_TDATA,
  output logic        OUTPUT_AXIS_TLAST,
  output logic        OUTPUT_AXIS_TVALID,
  input  logic        OUTPUT_AXIS_TREADY
);

  localparam int unsigned DATA_W = 32;

`ifdef ARGMAX_EMIT_VALUE_EN
  typedef enum logic [1:0] {S_RECV, S_SEND, S_SEND_VAL} state_e;
`else
  typedef enum logic [1:0] {S_RECV, S_SEND} state_e;
`endif

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    count_q, count_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic [DATA_W-1:0]   best_key_q, best_key_d;
  logic                err_q, err_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
`ifdef ARGMAX_EMIT_VALUE_EN
  logic [DATA_W-1:0]   best_val_q, best_val_d;
`endif

  logic [DATA_W-1:0]   in_key;
  logic                last_beat;

  // Sign-magnitude to monotonic unsigned: negatives invert, positives flip the sign bit.
  assign in_key    = INPUT_AXIS_TDATA[31] ? ~INPUT_AXIS_TDATA
                                          : (INPUT_AXIS_TDATA ^ 32'h8000_0000);
  assign last_beat = (count_q == IDX_W'(N_ELEMS - 1));

  assign INPUT_AXIS_TREADY  = in_ready_q;
  assign OUTPUT_AXIS_TVALID = out_valid_q;
  assign OUTPUT_AXIS_TDATA  = out_data_q;
  assign OUTPUT_AXIS_TLAST  = out_last_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    best_idx_d  = best_idx_q;
    best_key_d  = best_key_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
`ifdef ARGMAX_EMIT_VALUE_EN
    best_val_d  = best_val_q;
`endif
    case (state_q)
      S_RECV: begin
        if (INPUT_AXIS_TVALID) begin
          if ((count_q == '0) || (in_key > best_key_q)) begin
            best_key_d = in_key;
            best_idx_d = count_q;
`ifdef ARGMAX_EMIT_VALUE_EN
            best_val_d = INPUT_AXIS_TDATA;
`endif
          end
          count_d = count_q + IDX_W'(1);
          if (INPUT_AXIS_TLAST || last_beat) begin
            err_d       = INPUT_AXIS_TLAST ^ last_beat;
            state_d     = S_SEND;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_data_d  = {err_d, (DATA_W - 1)'(best_idx_d)};
`ifdef ARGMAX_EMIT_VALUE_EN
            out_last_d  = 1'b0;
`else
            out_last_d  = 1'b1;
`endif
          end
        end
      end
`ifdef ARGMAX_EMIT_VALUE_EN
      S_SEND: begin
        if (OUTPUT_AXIS_TREADY) begin
          state_d    = S_SEND_VAL;
          out_data_d = best_val_q;
          out_last_d = 1'b1;
        end
      end
      S_SEND_VAL: begin
`else
      S_SEND: begin
`endif
        if (OUTPUT_AXIS_TREADY) begin
          state_d     = S_RECV;
          count_d     = '0;
          err_d       = 1'b0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          out_data_d  = '0;
        end
      end
      default: begin
        state_d    = S_RECV;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q     <= S_RECV;
      count_q     <= '0;
      best_idx_q  <= '0;
      best_key_q  <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
`ifdef ARGMAX_EMIT_VALUE_EN
      best_val_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      best_idx_q  <= best_idx_d;
      best_key_q  <= best_key_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
`ifdef ARGMAX_EMIT_VALUE_EN
      best_val_q  <= best_val_d;
`endif
    end
  end

endmodule

// File: tb/tb_axis_argmax_10.sv
// Self-checking bench for axis_argmax_10: directed frames plus a random stream against a float-ordering model.
module tb_axis_argmax_10;

  localparam int unsigned N_ELEMS = 10;
  localparam int unsigned IDX_W   = 4;

  logic        aclk = 1'b0;
  logic        rst  = 1'b1;
  logic [31:0] in_data  = '0;
  logic        in_last  = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        dir_rdy  = 1'b1;
  logic        rnd_rdy  = 1'b1;
  logic        rand_rdy = 1'b0;
  bit          gap_en   = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_data[$];
  bit          exp_last[$];
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [31:0] m_best = '0;

  bit          hold_pend = 1'b0;
  logic [31:0] hold_data = '0;

  axis_argmax_10 #(.N_ELEMS(N_ELEMS), .IDX_W(IDX_W)) dut (
    .aclk               (aclk),
    .rst                (rst),
    .INPUT_AXIS_TDATA   (in_data),
    .INPUT_AXIS_TLAST   (in_last),
    .INPUT_AXIS_TVALID  (in_valid),
    .INPUT_AXIS_TREADY  (in_ready),
    .OUTPUT_AXIS_TDATA  (out_data),
    .OUTPUT_AXIS_TLAST  (out_last),
    .OUTPUT_AXIS_TVALID (out_valid),
    .OUTPUT_AXIS_TREADY (out_ready)
  );

  always #5 aclk = ~aclk;

  assign out_ready = rand_rdy ? rnd_rdy : dir_rdy;
  always @(posedge aclk) rnd_rdy <= ($urandom_range(0, 3) != 0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // True when float a orders above float b by sign, then magnitude.
  function automatic bit fp_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return !a[31];
    if (!a[31])         return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  // Feed one accepted word to the reference; queue expected result beats when the frame closes.
  task automatic model_push(input logic [31:0] d, input bit l);
    bit full;
    bit err;
    if (m_cnt == 0 || fp_gt(d, m_best)) begin
      m_best = d;
      m_idx  = m_cnt;
    end
    full = (m_cnt == N_ELEMS - 1);
    if (l || full) begin
      err = l ^ full;
`ifdef ARGMAX_EMIT_VALUE_EN
      exp_data.push_back({err, 31'(m_idx)}); exp_last.push_back(1'b0);
      exp_data.push_back(m_best);            exp_last.push_back(1'b1);
`else
      exp_data.push_back({err, 31'(m_idx)}); exp_last.push_back(1'b1);
`endif
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    exp_data.delete();
    exp_last.delete();
  endtask

  // Output monitor: checks every accepted beat and stability of stalled beats.
  always @(negedge aclk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, hold_data);
      end
      if (out_valid) check("in_ready_in_send", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          check("spurious_beat", 32'(exp_data.size()), 32'd1);
        end else begin
          check("out_data", out_data, exp_data.pop_front());
          check("out_last", 32'(out_last), 32'(exp_last.pop_front()));
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_word(input logic [31:0] d, input bit l);
    int t = 0;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      @(posedge aclk); #1;
    end
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge aclk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge aclk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge aclk); #1;
      in_valid = 1'b0;
      return;
    end
    @(posedge aclk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_push(d, l);
  endtask

  task automatic send_frame(input logic [31:0] w[10], input int n, input bit tl);
    for (int i = 0; i < n; i++) send_word(w[i], tl && (i == n - 1));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_data.size() != 0 && t < 2000) begin
      @(posedge aclk);
      t++;
    end
    #1;
    check("drain_empty", 32'(exp_data.size()), 32'd0);
  endtask

  localparam logic [31:0] IDX_LAST =
`ifdef ARGMAX_EMIT_VALUE_EN
    32'd0;
`else
    32'd1;
`endif

  initial begin
    logic [31:0] fr[10];
    logic [31:0] tp1[10];
    logic [31:0] pool[6];
    logic [31:0] d;
    pool = '{32'h3F00_0000, 32'hBF00_0000, 32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000, 32'hFF80_0000};
    tp1 = '{32'hBECA_3056, 32'hBEE9_5183, 32'hBEAC_BFB1, 32'hBEED_8530, 32'hBEA6_244A,
            32'h3E96_C8B4, 32'h3F9B_8E47, 32'hBE1A_36E3, 32'hBE2E_7D56, 32'hBE09_5182};

    repeat (3) @(posedge aclk);
    #1 rst = 1'b0;
    @(negedge aclk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge aclk); #1;

    // Nominal frame: result registered right after the 10th accept.
    send_frame(tp1, 10, 1'b1);
    check("tp1_valid", 32'(out_valid), 32'd1);
    check("tp1_data", out_data, 32'h0000_0006);
    check("tp1_last", 32'(out_last), IDX_LAST);
    check("tp1_in_ready", 32'(in_ready), 32'd0);
`ifdef ARGMAX_EMIT_VALUE_EN
    @(posedge aclk); #1;
    check("tp1_val_data", out_data, 32'h3F9B_8E47);
    check("tp1_val_last", 32'(out_last), 32'd1);
`endif
    @(posedge aclk); #1;
    check("tp1_done_valid", 32'(out_valid), 32'd0);
    check("tp1_in_ready_back", 32'(in_ready), 32'd1);

    // Ties keep the first index; signed zeros order above negatives, +0 above -0.
    for (int i = 0; i < 10; i++) fr[i] = 32'h3F00_0000;
    send_frame(fr, 10, 1'b1);
    check("tie_data", out_data, 32'h0000_0000);
    for (int i = 0; i < 10; i++) fr[i] = 32'hC000_0000;
    fr[3] = 32'h8000_0000;
    fr[7] = 32'h0000_0000;
    send_frame(fr, 10, 1'b1);
    check("zero_data", out_data, 32'h0000_0007);
    drain();

    // Early TLAST, then a normal frame.
    fr = '{32'hBF80_0000, 32'h3E80_0000, 32'h4040_0000, 32'h4000_0000, 0, 0, 0, 0, 0, 0};
    send_frame(fr, 4, 1'b1);
    check("early_data", out_data, 32'h8000_0002);
    fr = tp1;
    fr[2] = 32'h4100_0000;
    send_frame(fr, 10, 1'b1);
    check("after_early_data", out_data, 32'h0000_0002);
    drain();

    // Missing TLAST: frame closes on beat 10; the 11th word opens the next frame.
    for (int i = 0; i < 10; i++) fr[i] = 32'h3F80_0000 + 32'(i) * 32'h0010_0000;
    send_frame(fr, 10, 1'b0);
    check("notlast_data", out_data, 32'h8000_0009);
    send_word(32'h3F80_0000, 1'b1);
    check("eleventh_data", out_data, 32'h8000_0000);
    drain();

    // Output backpressure holds the result and blocks input.
    dir_rdy = 1'b0;
    send_frame(tp1, 10, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, 32'h0000_0006);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
`ifdef ARGMAX_EMIT_VALUE_EN
    @(posedge aclk); #1 dir_rdy = 1'b1;
    @(posedge aclk); #1 dir_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("bp_val_data", out_data, 32'h3F9B_8E47);
      check("bp_val_last", 32'(out_last), 32'd1);
    end
`endif
    @(posedge aclk); #1 dir_rdy = 1'b1;
    drain();

    // Reset mid-frame, then reset with a result pending.
    send_frame(tp1, 5, 1'b0);
    rst = 1'b1;
    @(posedge aclk); #1 rst = 1'b0;
    model_reset();
    check("rstf_valid", 32'(out_valid), 32'd0);
    check("rstf_in_ready", 32'(in_ready), 32'd1);
    dir_rdy = 1'b0;
    send_frame(tp1, 10, 1'b1);
    rst = 1'b1;
    @(posedge aclk); #1 rst = 1'b0;
    model_reset();
    check("rsts_valid", 32'(out_valid), 32'd0);
    check("rsts_data", out_data, 32'd0);
    dir_rdy = 1'b1;
    fr = tp1;
    fr[8] = 32'h4200_0000;
    send_frame(fr, 10, 1'b1);
    check("post_rst_data", out_data, 32'h0000_0008);
    drain();

    // Random stream with random gaps, TLAST placement and downstream stalls.
    gap_en   = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      d = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      send_word(d, $urandom_range(0, 9) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
